trace_record_arbiter: RTL and testbench

//  Shares one trace output channel between NUM_REQ stage trackers (IF tracker = req 0, further trackers 1..).

---
 rtl/gouram_trace_pkg.sv | 24 ++
 rtl/trace_fifo.sv | 57 +++++
 rtl/trace_record_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_trace_record_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gouram_trace_pkg.sv
// Shared types for the trace record arbiter: record layout, arbiter FSM states and requester limits.
package gouram_trace_pkg;

  localparam int MAX_REQ          = 8;
  localparam int TIME_WIDTH       = 32;
  localparam int DEF_NUM_REQ      = 2;
  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_DATA_WIDTH   = 32;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2
  } arb_state_e;

  // Record layout for the default configuration; out_rec of the arbiter uses the same field order.
  typedef struct packed {
    logic [$clog2(DEF_NUM_REQ)-1:0] src_id;
    logic [DEF_DATA_WIDTH-1:0]      instruction;
    logic [DEF_ADDR_WIDTH-1:0]      instr_addr;
    logic [TIME_WIDTH-1:0]          stage_end;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO: head entry is presented from registered storage whenever the FIFO is non-empty.
module trace_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr_reg;
  logic [PW-1:0]  rd_ptr_reg;
  logic [PW:0]    count_reg;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_reg + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/trace_record_arbiter.sv
// Latches one-cycle tracker pulses into per-requester holds and round-robins them into a trace FIFO.
// Optional macro TRACE_ARB_DROP_COUNT_EN adds per-requester saturating drop counters (drop_count).
module trace_record_arbiter
  import gouram_trace_pkg::*;
#(
  parameter int  NUM_REQ          = 2,
  parameter int  INSTR_ADDR_WIDTH = 16,
  parameter int  INSTR_DATA_WIDTH = 32,
  parameter int  FIFO_DEPTH       = 4,
  localparam int SRC_W            = $clog2(NUM_REQ),
  localparam int REC_W            = SRC_W + INSTR_DATA_WIDTH + INSTR_ADDR_WIDTH + TIME_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                trace_en,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*INSTR_DATA_WIDTH-1:0] req_instr,
  input  logic [NUM_REQ*INSTR_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*TIME_WIDTH-1:0]       req_time,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [REC_W-1:0]                    out_rec,
  output logic [NUM_REQ-1:0]                  overflow,
`ifdef TRACE_ARB_DROP_COUNT_EN
  output logic [NUM_REQ*16-1:0]               drop_count,
`endif
  output logic                                busy
);

  typedef struct packed {
    logic [SRC_W-1:0]            src_id;
    logic [INSTR_DATA_WIDTH-1:0] instruction;
    logic [INSTR_ADDR_WIDTH-1:0] instr_addr;
    logic [TIME_WIDTH-1:0]       stage_end;
  } rec_t;

  typedef struct packed {
    logic [INSTR_DATA_WIDTH-1:0] instruction;
    logic [INSTR_ADDR_WIDTH-1:0] instr_addr;
    logic [TIME_WIDTH-1:0]       stage_end;
  } hold_t;

  arb_state_e                    state_reg;
  arb_state_e                    state_next;
  logic                          capture_en;
  logic [NUM_REQ-1:0]            hold_valid;
  hold_t [NUM_REQ-1:0]           hold_data;
  logic [SRC_W-1:0]              rr_ptr_reg;
  logic                          grant_valid;
  logic [SRC_W-1:0]              grant_idx;
  logic                          fifo_empty;
  logic                          fifo_full;
  logic                          fifo_pop;
  logic                          fifo_can_push;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  rec_t                          push_rec;
  rec_t                          head_rec;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= DISABLED;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture_en = 1'b0;
    busy       = 1'b1;
    unique case (state_reg)
      DISABLED: begin
        busy = 1'b0;
        if (trace_en) state_next = RUN;
      end
      RUN: begin
        capture_en = 1'b1;
        if (!trace_en) state_next = DRAIN;
      end
      DRAIN: begin
        if (trace_en) begin
          state_next = RUN;
        end else if ((hold_valid == '0) && (fifo_count == '0)) begin
          state_next = DISABLED;
        end
      end
      default: state_next = DISABLED;
    endcase
  end

  // ---------------- Round-robin arbitration ----------------
  assign fifo_pop      = !fifo_empty && out_ready;
  assign fifo_can_push = !fifo_full || fifo_pop;

  always_comb begin
    int               sum;
    logic [SRC_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = 0;
    cand        = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      sum = int'(rr_ptr_reg) + o;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = SRC_W'(sum);
      if (!grant_valid && hold_valid[cand] && fifo_can_push) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (grant_valid) begin
      rr_ptr_reg <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  always_comb begin
    push_rec             = '0;
    push_rec.src_id      = grant_idx;
    push_rec.instruction = hold_data[grant_idx].instruction;
    push_rec.instr_addr  = hold_data[grant_idx].instr_addr;
    push_rec.stage_end   = hold_data[grant_idx].stage_end;
  end

  // ---------------- Per-requester holds and drop tracking ----------------
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hold
    logic  valid_reg;
    hold_t data_reg;
    logic  ovf_reg;
    logic  granted;
    logic  accept;
    logic  drop;

    assign granted = grant_valid && (grant_idx == SRC_W'(gi));
    // A hold being emptied this cycle can take the new pulse without losing anything.
    assign accept  = capture_en && req_valid[gi] && (!valid_reg || granted);
    assign drop    = capture_en && req_valid[gi] && valid_reg && !granted;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
        ovf_reg   <= 1'b0;
      end else begin
        if (accept) begin
          valid_reg            <= 1'b1;
          data_reg.instruction <= req_instr[gi*INSTR_DATA_WIDTH +: INSTR_DATA_WIDTH];
          data_reg.instr_addr  <= req_addr[gi*INSTR_ADDR_WIDTH +: INSTR_ADDR_WIDTH];
          data_reg.stage_end   <= req_time[gi*TIME_WIDTH +: TIME_WIDTH];
        end else if (granted) begin
          valid_reg <= 1'b0;
        end
        if (drop) begin
          ovf_reg <= 1'b1;
        end
      end
    end

    assign hold_valid[gi] = valid_reg;
    assign hold_data[gi]  = data_reg;
    assign overflow[gi]   = ovf_reg;

`ifdef TRACE_ARB_DROP_COUNT_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        drop_cnt_reg <= '0;
      end else if (drop && (drop_cnt_reg != 16'hFFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end

    assign drop_count[gi*16 +: 16] = drop_cnt_reg;
`endif
  end

  // ---------------- Output FIFO ----------------
  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_valid),
    .push_data (push_rec),
    .pop       (fifo_pop),
    .head_data (head_rec),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_rec   = head_rec;

endmodule

// File: tb/tb_trace_record_arbiter.sv
// Directed self-checking bench for trace_record_arbiter in its default 2-requester configuration.
module tb_trace_record_arbiter;
  import gouram_trace_pkg::*;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              trace_en;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_instr;
  logic [N*AW-1:0]   req_addr;
  logic [N*32-1:0]   req_time;
  logic              out_valid;
  logic              out_ready;
  trace_rec_t        out_rec;
  logic [N-1:0]      overflow;
  logic              busy;
`ifdef TRACE_ARB_DROP_COUNT_EN
  logic [N*16-1:0]   drop_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trace_record_arbiter #(
    .NUM_REQ          (N),
    .INSTR_ADDR_WIDTH (AW),
    .INSTR_DATA_WIDTH (DW),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trace_en   (trace_en),
    .req_valid  (req_valid),
    .req_instr  (req_instr),
    .req_addr   (req_addr),
    .req_time   (req_time),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rec    (out_rec),
    .overflow   (overflow),
`ifdef TRACE_ARB_DROP_COUNT_EN
    .drop_count (drop_count),
`endif
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic trace_rec_t mk(input int src, input int tag);
    trace_rec_t r;
    r.src_id      = 1'(src);
    r.instruction = 32'hA500_0000 | 32'(tag << 8) | 32'(src);
    r.instr_addr  = 16'(tag * 4 + src * 2);
    r.stage_end   = 32'(tag * 10 + src);
    return r;
  endfunction

  task automatic load_req(input int i, input trace_rec_t r);
    req_instr[i*DW +: DW] = r.instruction;
    req_addr[i*AW +: AW]  = r.instr_addr;
    req_time[i*32 +: 32]  = r.stage_end;
  endtask

  task automatic pulse(input logic [N-1:0] mask, input int tag);
    for (int i = 0; i < N; i++) load_req(i, mk(i, tag));
    req_valid = mask;
    tick();
    req_valid = '0;
  endtask

  // Waits (bounded) for a head record with out_ready high, checks it, and lets it pop.
  task automatic pop_expect(input string tag, input trace_rec_t exp);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
    if (out_valid) begin
      check_eq(tag, 128'(out_rec), 128'(exp));
      $display("pop %s src=%0d instr=%h addr=%h time=%0d", tag, out_rec.src_id,
               out_rec.instruction, out_rec.instr_addr, out_rec.stage_end);
    end
    tick();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    trace_en  = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    trace_rec_t r1;
    req_instr = '0;
    req_addr  = '0;
    req_time  = '0;
    do_reset();
    tick();

    // Reset state
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_out_rec", 128'(out_rec), 128'(0));
    check_eq("rst_overflow", 128'(overflow), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
`ifdef TRACE_ARB_DROP_COUNT_EN
    check_eq("rst_drop_count", 128'(drop_count), 128'(0));
`endif

    // 1: single record, two-cycle latency, one beat
    trace_en  = 1'b1;
    out_ready = 1'b1;
    tick();
    check_eq("t1_busy", 128'(busy), 128'(1));
    r1.src_id = 1'b0; r1.instruction = 32'h0041_2083; r1.instr_addr = 16'h0100; r1.stage_end = 32'd10;
    load_req(0, r1);
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    check_eq("t1_lat1", 128'(out_valid), 128'(0));
    tick();
    check_eq("t1_lat2", 128'(out_valid), 128'(1));
    check_eq("t1_rec", 128'(out_rec), 128'(r1));
    $display("pop t1 src=%0d instr=%h addr=%h time=%0d", out_rec.src_id, out_rec.instruction,
             out_rec.instr_addr, out_rec.stage_end);
    tick();
    check_eq("t1_one_beat", 128'(out_valid), 128'(0));

    // 2: simultaneous pulses, round-robin order 0,1,0,1
    do_reset();
    trace_en  = 1'b1;
    out_ready = 1'b1;
    tick();
    pulse(2'b11, 2);
    pop_expect("t2_a0", mk(0, 2));
    pop_expect("t2_a1", mk(1, 2));
    pulse(2'b11, 3);
    pop_expect("t2_b0", mk(0, 3));
    pop_expect("t2_b1", mk(1, 3));

    // 3: back-pressure fills FIFO and holds, 7th pulse drops on req0
    do_reset();
    trace_en = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) pulse((k % 2 == 1) ? 2'b10 : 2'b01, 10 + k);
    check_eq("t3_no_ovf", 128'(overflow), 128'(0));
    pulse(2'b01, 99);
    check_eq("t3_ovf", 128'(overflow), 128'(2'b01));
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) pop_expect($sformatf("t3_p%0d", k), mk(k % 2, 10 + k));
    tick(); tick(); tick();
    check_eq("t3_empty", 128'(out_valid), 128'(0));
    check_eq("t3_ovf_sticky", 128'(overflow), 128'(2'b01));

    // 4: grant and new pulse on req1 in the same cycle
    do_reset();
    trace_en  = 1'b1;
    out_ready = 1'b1;
    tick();
    pulse(2'b10, 40);
    pulse(2'b10, 41);
    check_eq("t4_no_ovf", 128'(overflow), 128'(0));
    pop_expect("t4_a", mk(1, 40));
    pop_expect("t4_b", mk(1, 41));

    // 5: drain after trace_en drops
    do_reset();
    trace_en = 1'b1;
    tick();
    pulse(2'b01, 50);
    pulse(2'b10, 51);
    pulse(2'b01, 52);
    tick(); tick();
    trace_en = 1'b0;
    tick();
    check_eq("t5_busy_drain", 128'(busy), 128'(1));
    pulse(2'b01, 59);
    check_eq("t5_busy_drain2", 128'(busy), 128'(1));
    out_ready = 1'b1;
    pop_expect("t5_a", mk(0, 50));
    pop_expect("t5_b", mk(1, 51));
    pop_expect("t5_c", mk(0, 52));
    check_eq("t5_busy_last", 128'(busy), 128'(1));
    tick();
    check_eq("t5_busy_done", 128'(busy), 128'(0));
    check_eq("t5_ignored", 128'(out_valid), 128'(0));
    check_eq("t5_no_ovf", 128'(overflow), 128'(0));

    // 6: reset with queued records and a sticky overflow
    do_reset();
    trace_en = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) pulse(2'b01, 60 + k);
    check_eq("t6_ovf_pre", 128'(overflow), 128'(2'b01));
    check_eq("t6_valid_pre", 128'(out_valid), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_out_valid", 128'(out_valid), 128'(0));
    check_eq("t6_overflow", 128'(overflow), 128'(0));
    check_eq("t6_busy", 128'(busy), 128'(0));
    check_eq("t6_out_rec", 128'(out_rec), 128'(0));

`ifdef TRACE_ARB_DROP_COUNT_EN
    do_reset();
    trace_en = 1'b1;
    tick();
    load_req(0, mk(0, 70));
    req_valid = 2'b01;
    for (int k = 0; k < 70010; k++) tick();
    req_valid = '0;
    check_eq("t6_drop_sat", 128'(drop_count[15:0]), 128'(16'hFFFF));
    check_eq("t6_drop_req1", 128'(drop_count[31:16]), 128'(0));
    check_eq("t6_drop_ovf", 128'(overflow), 128'(2'b01));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
